// File: rtl/vga_pkg.sv
// Shared constants and slot-phase encoding for the VGA table fetch arbiter.
package vga_pkg;

  localparam logic [15:0] TABLE_BASE_DEF = 16'hFFF0;
  localparam int unsigned TABLE_SIZE     = 8;
  localparam int unsigned IDX_W          = $clog2(TABLE_SIZE);

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_CAPTURE = 2'd1,
    PH_CPU     = 2'd2,
    PH_ACK     = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_fetch_arbiter_if.sv
// CPU request/response bus and synchronous RAM port shared by the arbiter.
interface vga_fetch_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [15:0]      cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_ack;
  logic             cpu_stall;
  logic [15:0]      mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fetch_arbiter.sv
// Shares one synchronous RAM between a 4-clock VGA table fetch slot and at most one
// CPU access per slot; the VGA fetch always owns phase 0, the CPU only phase 2.
module vga_fetch_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter logic [15:0] TABLE_BASE = TABLE_BASE_DEF
) (
  input  logic                 clk_50MHz,
  input  logic                 clear,
  vga_fetch_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]     data_from_mem_vga,
  output logic [IDX_W-1:0]     vga_counter
);

  phase_e           phase_q, phase_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             grant_q, grant_d;
  logic             gwe_q, gwe_d;
  logic             ack_q, ack_d;
  logic [IDX_W-1:0] next_idx;

  assign next_idx = cnt_q + 1'b1;

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    rdata_d  = rdata_q;
    grant_d  = grant_q;
    gwe_d    = gwe_q;
    ack_d    = ack_q;
    unique case (phase_q)
      PH_FETCH: phase_d = PH_CAPTURE;
      PH_CAPTURE: begin
        // RAM returns the phase-0 fetch now; the CPU request is also decided here.
        shadow_d = bus.mem_rdata;
        grant_d  = bus.cpu_req;
        gwe_d    = bus.cpu_we;
        phase_d  = PH_CPU;
      end
      PH_CPU: begin
        ack_d   = grant_q;
        phase_d = PH_ACK;
      end
      PH_ACK: begin
        if (ack_q && !gwe_q) rdata_d = bus.mem_rdata;
        ack_d   = 1'b0;
        grant_d = 1'b0;
        cnt_d   = next_idx;
        disp_d  = shadow_q;
        phase_d = PH_FETCH;
      end
      default: phase_d = PH_FETCH;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      phase_q  <= PH_FETCH;
      cnt_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      rdata_q  <= '0;
      grant_q  <= 1'b0;
      gwe_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      rdata_q  <= rdata_d;
      grant_q  <= grant_d;
      gwe_q    <= gwe_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (phase_q == PH_FETCH) begin
      bus.mem_addr = TABLE_BASE + {{(16 - IDX_W){1'b0}}, next_idx};
    end else if (phase_q == PH_CPU && grant_q) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = gwe_q;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // Read data is live from the RAM during the ack clock, then held in rdata_q.
  assign bus.cpu_rdata      = (ack_q && !gwe_q) ? bus.mem_rdata : rdata_q;
  assign bus.cpu_ack        = ack_q;
  assign bus.cpu_stall      = bus.cpu_req & ~ack_q;
  assign data_from_mem_vga  = disp_q;
  assign vga_counter        = cnt_q;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter: table fill, CPU read/late request vectors,
// write collision, back-to-back access and mid-access reset.
module tb_vga_fetch_arbiter;

  logic        clk = 1'b0;
  logic        clear;
  logic [15:0] dvga;
  logic [2:0]  vcnt;
  logic [15:0] ram [0:65535];
  int          total = 0;
  int          bad   = 0;

  always #10 clk = ~clk;

  vga_fetch_arbiter_if #(.WIDTH(16)) bus ();

  vga_fetch_arbiter #(
    .WIDTH      (16),
    .TABLE_BASE (16'hFFF0)
  ) dut (
    .clk_50MHz         (clk),
    .clear             (clear),
    .bus               (bus),
    .data_from_mem_vga (dvga),
    .vga_counter       (vcnt)
  );

  // Synchronous RAM: read data valid one clock after the address.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic [2:0]  cnt;
    logic [15:0] data;
    logic [15:0] fetch;
  } fill_t;

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] e_maddr;
    logic        e_mwe;
    logic        e_ack;
    logic        e_stall;
    logic [15:0] e_rdata;
  } vec_t;

  fill_t fill [8];
  vec_t  vec  [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] <= 16'h0000;
    for (int i = 0; i < 8; i++) ram[16'hFFF0 + i] <= 16'hA000 + 16'(i);
    ram[16'h0010] <= 16'h1234;
    ram[16'h0020] <= 16'h5678;
  end

  initial begin
    logic [15:0] exp_d;
    logic [15:0] e_fetch;
    int          last_ack;
    int          acks;

    fill[0] = '{3'd1, 16'hA001, 16'hFFF1};
    fill[1] = '{3'd2, 16'hA002, 16'hFFF2};
    fill[2] = '{3'd3, 16'hA003, 16'hFFF3};
    fill[3] = '{3'd4, 16'hA004, 16'hFFF4};
    fill[4] = '{3'd5, 16'hA005, 16'hFFF5};
    fill[5] = '{3'd6, 16'hA006, 16'hFFF6};
    fill[6] = '{3'd7, 16'hA007, 16'hFFF7};
    fill[7] = '{3'd0, 16'hA000, 16'hFFF0};

    //           req   we    addr      wdata   maddr     mwe   ack   stall rdata
    vec[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0, 16'hFFF3, 1'b0, 1'b0, 1'b1, 16'h0000};
    vec[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    vec[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0000};
    vec[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234};
    vec[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0, 16'hFFF4, 1'b0, 1'b0, 1'b0, 16'h1234};
    vec[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234};
    vec[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234};
    vec[7]  = '{1'b1, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234};
    vec[8]  = '{1'b1, 1'b0, 16'h0020, 16'h0, 16'hFFF5, 1'b0, 1'b0, 1'b1, 16'h1234};
    vec[9]  = '{1'b1, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234};
    vec[10] = '{1'b1, 1'b0, 16'h0020, 16'h0, 16'h0020, 1'b0, 1'b0, 1'b1, 16'h1234};
    vec[11] = '{1'b1, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5678};
    vec[12] = '{1'b0, 1'b0, 16'h0000, 16'h0, 16'hFFF6, 1'b0, 1'b0, 1'b0, 16'h5678};
    vec[13] = '{1'b0, 1'b0, 16'h0000, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5678};
    vec[14] = '{1'b0, 1'b0, 16'h0000, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5678};
    vec[15] = '{1'b0, 1'b0, 16'h0000, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5678};

    clear         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_wdata = 16'h0;
    tick();
    tick();
    chk("rst_cnt",   vcnt, 3'd0);
    chk("rst_data",  dvga, 16'h0);
    chk("rst_ack",   bus.cpu_ack, 1'b0);
    chk("rst_rdata", bus.cpu_rdata, 16'h0);
    chk("rst_mwe",   bus.mem_we, 1'b0);
    chk("rst_maddr", bus.mem_addr, 16'hFFF1);
    clear = 1'b0;

    // Table fill: ten slots with no CPU traffic.
    exp_d = 16'h0;
    for (int s = 0; s < 10; s++) begin
      chk("fill_fetch", bus.mem_addr, fill[s % 8].fetch);
      chk("fill_mwe",   bus.mem_we, 1'b0);
      tick();
      tick();
      chk("fill_hold",  dvga, exp_d);
      tick();
      tick();
      chk("fill_cnt",   vcnt, fill[s % 8].cnt);
      chk("fill_data",  dvga, fill[s % 8].data);
      exp_d = fill[s % 8].data;
    end

    // CPU read raised in phase 0, then a late request raised in phase 2.
    for (int i = 0; i < 16; i++) begin
      bus.cpu_req   = vec[i].req;
      bus.cpu_we    = vec[i].we;
      bus.cpu_addr  = vec[i].addr;
      bus.cpu_wdata = vec[i].wdata;
      #1;
      chk("vec_maddr", bus.mem_addr, vec[i].e_maddr);
      chk("vec_mwe",   bus.mem_we, vec[i].e_mwe);
      chk("vec_ack",   bus.cpu_ack, vec[i].e_ack);
      chk("vec_stall", bus.cpu_stall, vec[i].e_stall);
      chk("vec_rdata", bus.cpu_rdata, vec[i].e_rdata);
      tick();
    end

    // Write collision: slot with vga_counter=2 fetches FFF3 while the CPU writes it.
    for (int k = 0; k < 16; k++) tick();
    chk("col_cnt2", vcnt, 3'd2);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'hFFF3;
    bus.cpu_wdata = 16'hBEEF;
    tick();
    tick();
    chk("col_maddr", bus.mem_addr, 16'hFFF3);
    chk("col_mwe",   bus.mem_we, 1'b1);
    chk("col_wdata", bus.mem_wdata, 16'hBEEF);
    tick();
    chk("col_ack",   bus.cpu_ack, 1'b1);
    chk("col_rdata", bus.cpu_rdata, 16'h5678);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    chk("col_old_cnt",  vcnt, 3'd3);
    chk("col_old_data", dvga, 16'hA003);
    for (int k = 0; k < 32; k++) tick();
    chk("col_new_cnt",  vcnt, 3'd3);
    chk("col_new_data", dvga, 16'hBEEF);

    // Back-to-back: three reads with cpu_req held, starting in the vga_counter=3 slot.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    last_ack     = -1;
    acks         = 0;
    for (int k = 0; k < 16; k++) begin
      chk("b2b_ack", bus.cpu_ack, ((k % 4 == 3) && (k < 12)) ? 1'b1 : 1'b0);
      if (k % 4 == 0) begin
        e_fetch = 16'hFFF0 + 16'((4 + k / 4) % 8);
        chk("b2b_fetch", bus.mem_addr, e_fetch);
      end
      if (k % 4 == 2) chk("b2b_cpu_addr", bus.mem_addr, (k < 12) ? 16'h0010 : 16'h0000);
      if (bus.cpu_ack === 1'b1) begin
        acks++;
        if (last_ack >= 0) chk("b2b_gap", k - last_ack, 4);
        last_ack = k;
        if (k == 11) bus.cpu_req = 1'b0;
      end
      tick();
    end
    chk("b2b_count", acks, 3);

    // Clear during phase 2 of a granted write.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0030;
    bus.cpu_wdata = 16'h1111;
    tick();
    tick();
    chk("mid_mwe_pre", bus.mem_we, 1'b1);
    clear       = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    chk("mid_ack",   bus.cpu_ack, 1'b0);
    chk("mid_mwe",   bus.mem_we, 1'b0);
    chk("mid_cnt",   vcnt, 3'd0);
    chk("mid_data",  dvga, 16'h0);
    chk("mid_rdata", bus.cpu_rdata, 16'h0);
    chk("mid_maddr", bus.mem_addr, 16'hFFF1);
    clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mid_no_ack", bus.cpu_ack, 1'b0);
      tick();
    end
    chk("mid_cnt1",  vcnt, 3'd1);
    chk("mid_data1", dvga, 16'hA001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fetch_arbiter.md
VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16; data word width.
REQ-002 SHALL have parameter TABLE_BASE, default 16'hFFF0; address of VGA table entry 0.
REQ-003 SHALL have ports: clk_50MHz input 1, sole clock; clear input 1, synchronous active-high reset.
REQ-004 SHALL have ports: cpu_req in 1; cpu_we in 1; cpu_addr in 16; cpu_wdata in WIDTH; cpu_rdata out WIDTH; cpu_ack out 1; cpu_stall out 1.
REQ-005 SHALL have ports: mem_addr out 16; mem_we out 1; mem_wdata out WIDTH; mem_rdata in WIDTH, valid one clock after mem_addr (synchronous RAM).
REQ-006 SHALL have ports: data_from_mem_vga out WIDTH, table word for the current entry; vga_counter out 3, current entry index.

Function
REQ-007 SHALL run a free-running 2-bit slot phase, 0->1->2->3->0, one step per clock.
REQ-008 SHALL increment vga_counter modulo 8 on each phase 3->0 transition, so one slot is 4 clocks and wrap 7->0 is silent.
REQ-009 SHALL drive phase 0: mem_addr = TABLE_BASE + ((vga_counter+1) mod 8), mem_we = 0.
REQ-010 SHALL capture mem_rdata into an internal shadow register in phase 1.
REQ-011 SHALL load data_from_mem_vga from shadow on the phase 3->0 edge, same edge as the vga_counter increment, so the two outputs always pair.
REQ-012 SHALL hold data_from_mem_vga stable for all 4 clocks of a slot.
REQ-013 SHALL reserve phase 2 for at most one CPU access per slot, only if cpu_req = 1 when sampled at end of phase 1.
REQ-014 SHALL drive, on a granted phase 2: mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
REQ-015 SHALL, in phase 3 of a granted slot, pulse cpu_ack high for exactly one clock and present cpu_rdata = mem_rdata for reads; for writes cpu_rdata holds its previous value.
REQ-016 SHALL keep cpu_rdata registered and unchanged between acks.
REQ-017 SHALL require the CPU to hold cpu_req, cpu_we, cpu_addr and cpu_wdata stable until cpu_ack; cpu_req dropping before grant cancels the access with no ack.
REQ-018 SHALL drive cpu_stall = cpu_req & ~cpu_ack, combinational.
REQ-019 SHALL drive mem_we = 0 and mem_addr = 0 in phases 1 and 3, and in phase 2 when no grant.
REQ-020 SHALL, when a CPU write in phase 2 targets the entry fetched in phase 0 of the same slot, present the pre-write value for that slot; the new value appears on the next wrap.
REQ-021 SHALL accept a new cpu_req asserted in the ack clock only in the following slot; back-to-back accesses are 4 clocks apart.

Reset
REQ-022 SHALL, on clear = 1 at a clock edge, set phase = 0, vga_counter = 0, data_from_mem_vga = 0, shadow = 0, cpu_rdata = 0, cpu_ack = 0, and drop any pending grant.
REQ-023 SHALL, when clear is asserted mid-access, leave no cpu_ack issued for the aborted access; mem_we SHALL be 0 in the clock after clear.
REQ-024 SHALL make the first clock after clear deasserts phase 0, fetching entry 1.

Structure
REQ-025 SHALL place TABLE_BASE default, slot phase encodings (PH_FETCH=0, PH_CAPTURE=1, PH_CPU=2, PH_ACK=3) and table size 8 in shared package vga_pkg.
REQ-026 SHALL be a single flat module; no sub-module is required.

Verification
REQ-027 SHALL cover table fill: RAM[FFF0+i] = 16'hA000+i, no CPU traffic, 40 clocks after reset -> on each slot boundary, pairs (vga_counter, data) are (1,A001), (2,A002) ... (7,A007), (0,A000).
REQ-028 SHALL cover CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x0010 (RAM=0x1234) raised in phase 0 -> mem_addr=0x0010 in phase 2, cpu_ack and cpu_rdata=0x1234 in phase 3, cpu_stall high 3 clocks.
REQ-029 SHALL cover CPU write collision: write 0xBEEF to FFF3 during slot vga_counter=2 -> slot 3 shows old value; next wrap shows 0xBEEF with vga_counter=3.
REQ-030 SHALL cover back-to-back: cpu_req held across 3 accesses -> cpu_ack pulses exactly 4 clocks apart; VGA phase-0 fetches never displaced.
REQ-031 SHALL cover mid-access reset: clear=1 in phase 2 of a granted write -> no cpu_ack, mem_we=0 next clock, all outputs at reset values.
REQ-032 SHALL cover late request: cpu_req raised in phase 2 -> grant in next slot's phase 2, ack 4 clocks after the request's phase-3 clock.
